psum_accumulator: RTL and testbench
===================================

// Module: psum_accumulator
// PURPOSE
//  Sits directly downstream of the 36-input MAC adder tree. Accumulates cfg_num_pass
//  successive 22-bit partial sums into one output pixel, adds a bias, then round-shifts
//  and saturates the result to OUT_W bits. Streams cfg_num_out pixels per job and
//  pulses done. Neither side has backpressure: the adder tree cannot stall.
// PARAMETERS
//  IN_W    22  width of signed partial sum from adder tree
//  ACC_W   32  internal signed accumulator width (>= IN_W+PASS_W+1)
//  OUT_W   8   signed output width
//  PASS_W  8   width of pass counter / cfg_num_pass
//  CNT_W   16  width of pixel counter / cfg_num_out
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous active-high reset
//  start_i       in   1       1-cycle pulse; latches cfg_*, starts a job (IDLE only)
//  cfg_num_pass  in   PASS_W  partial sums per pixel; 0 treated as 1
//  cfg_num_out   in   CNT_W   pixels per job; 0 -> job finishes immediately (done next cycle)
//  cfg_shift     in   5       arithmetic right shift applied before saturation
//  cfg_bias      in   16      signed bias, added once per pixel at accumulator scale
//  vld_i         in   1       partial-sum valid (from adder tree vld_o)
//  acc_i         in   IN_W    signed partial sum (from adder tree acc_o)
//  data_o        out  OUT_W   signed quantised pixel
//  vld_o         out  1       1-cycle strobe, data_o valid
//  busy_o        out  1       high in RUN or DRAIN
//  done_o        out  1       1-cycle pulse after last pixel's vld_o cycle
//  err_o         out  1       sticky: vld_i seen in IDLE; cleared by next start_i
// BEHAVIOUR
//  - Reset: state=IDLE; all counters, psum, data_o=0, vld_o=0, busy_o=0, done_o=0, err_o=0.
//  - FSM: IDLE -start_i-> RUN. RUN -last pass of last pixel accepted-> DRAIN.
//    DRAIN -(1 cycle)-> DONE -> IDLE. DONE asserts done_o for exactly 1 cycle.
//  - RUN: each vld_i adds sign-extended acc_i to psum; pass_cnt++. First pass of a pixel
//    loads psum = acc_i (no clear bubble). Last pass (pass_cnt==num_pass-1) sends
//    psum+acc_i+bias to stage 2, resets pass_cnt, increments pix_cnt.
//  - Stage 2 (registered): if shift>0 add 1<<(shift-1); arithmetic >>shift; saturate to
//    [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Registered to data_o and vld_o.
//  - Latency: last-pass vld_i at cycle t -> vld_o at t+2. Back-to-back pixels with
//    num_pass=1 yield 1 pixel/cycle.
//  - No vld_i gaps are required; gaps simply hold state.
//  - vld_i in IDLE/DONE: ignored, sets err_o. vld_i in DRAIN: ignored, sets err_o.
//  - start_i outside IDLE: ignored. start_i and vld_i in the same IDLE cycle: cfg is
//    latched, that vld_i is dropped and flags err_o.
//  - Width: ACC_W headroom ensures no accumulator overflow for 2^PASS_W-1 passes.
//    Saturation is the only clipping point.
//  - rst mid-job: immediate return to IDLE; any partial pixel is discarded, no vld_o/done_o.
// CONFIGURATION
//  PSUM_ACC_RELU_EN defined: negative post-shift values clamp to 0 before saturation
//    (range [0, 2^(OUT_W-1)-1]).
//  Not defined: plain signed saturation; no ReLU logic is instantiated.
// STRUCTURE
//  mac_pkg (shared include): IN_W/ACC_W/OUT_W defaults, FSM state encodings
//    (IDLE/RUN/DRAIN/DONE), saturation bounds.
//  Sub-module requant_sat: combinational round + shift + (ReLU) + saturate.
//    Reused by other output stages.
// TESTING
//  1. num_pass=4, out=1, shift=0, bias=0, acc_i=10,20,30,40 -> data_o=100 clipped to
//     127? No: 100, vld_o at t+2, done_o next cycle.
//  2. num_pass=1, out=3, shift=2, bias=2, acc_i=5,-7,1000 back-to-back
//     -> data_o=2,-1,127 on 3 consecutive cycles.
//  3. Rounding: num_pass=1, shift=1, bias=0, acc_i=3 -> 2; acc_i=-3 -> -1.
//  4. ReLU: acc_i=-50, shift=0 -> -50 without macro, 0 with PSUM_ACC_RELU_EN.
//  5. Error/ignore: vld_i in IDLE -> err_o=1 and no vld_o; start_i during RUN -> cfg
//     unchanged; next start_i clears err_o.
//  6. rst asserted after 2 of 4 passes -> IDLE, busy_o=0, no vld_o. New job of 4 passes
//     of 1 -> data_o=4.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC output-stage definitions: default widths, psum FSM encodings, saturation bounds.
package mac_pkg;

  localparam int DEF_IN_W   = 22;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_PASS_W = 8;
  localparam int DEF_CNT_W  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int sat_max(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: round-half-up, arithmetic right shift, optional ReLU, signed saturate.
// Optional ReLU clamp is enabled by defining PSUM_ACC_RELU_EN.
module requant_sat
  import mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] din,
  input  logic        [4:0]       shift,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [ACC_W:0] MAX_V = (ACC_W + 1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] MIN_V = (ACC_W + 1)'(sat_min(OUT_W));

  // One guard bit so the rounding add can never wrap.
  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    ext = {din[ACC_W-1], din};
    rnd = '0;
    if (shift != 5'd0) rnd[shift - 5'd1] = 1'b1;
    rounded = ext + rnd;
    shifted = rounded >>> shift;
`ifdef PSUM_ACC_RELU_EN
    if (shifted < 0) shifted = '0;
`endif
    if (shifted > MAX_V)
      dout = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V)
      dout = MIN_V[OUT_W-1:0];
    else
      dout = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator behind the MAC adder tree: per-pixel accumulate + bias, then requantise.
// Define PSUM_ACC_RELU_EN to clamp negative results to zero in the requant stage.
module psum_accumulator
  import mac_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int PASS_W = DEF_PASS_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic        [PASS_W-1:0] cfg_num_pass,
  input  logic        [CNT_W-1:0]  cfg_num_out,
  input  logic        [4:0]        cfg_shift,
  input  logic signed [15:0]       cfg_bias,
  input  logic                     vld_i,
  input  logic signed [IN_W-1:0]   acc_i,
  output logic signed [OUT_W-1:0]  data_o,
  output logic                     vld_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  logic [1:0]               state_reg;
  logic [PASS_W-1:0]        num_pass_reg;
  logic [PASS_W-1:0]        pass_cnt_reg;
  logic [CNT_W-1:0]         num_out_reg;
  logic [CNT_W-1:0]         pix_cnt_reg;
  logic [4:0]               shift_reg;
  logic signed [ACC_W-1:0]  bias_reg;
  logic signed [ACC_W-1:0]  psum_reg;
  logic signed [ACC_W-1:0]  s1_sum_reg;
  logic                     s1_vld_reg;
  logic signed [OUT_W-1:0]  data_reg;
  logic                     vld_reg;
  logic                     done_reg;
  logic                     err_reg;

  logic signed [ACC_W-1:0]  acc_ext;
  logic signed [ACC_W-1:0]  psum_base;
  logic signed [ACC_W-1:0]  pass_sum;
  logic signed [OUT_W-1:0]  q_data;
  logic                     last_pass;
  logic                     last_pix;

  // First pass of a pixel overwrites psum instead of needing a clear cycle.
  assign acc_ext   = ACC_W'(acc_i);
  assign psum_base = (pass_cnt_reg == '0) ? '0 : psum_reg;
  assign pass_sum  = psum_base + acc_ext;
  assign last_pass = (pass_cnt_reg == num_pass_reg - 1'b1);
  assign last_pix  = (pix_cnt_reg == num_out_reg - 1'b1);

  requant_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .din   (s1_sum_reg),
    .shift (shift_reg),
    .dout  (q_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      num_pass_reg <= '0;
      pass_cnt_reg <= '0;
      num_out_reg  <= '0;
      pix_cnt_reg  <= '0;
      shift_reg    <= '0;
      bias_reg     <= '0;
      psum_reg     <= '0;
      s1_sum_reg   <= '0;
      s1_vld_reg   <= 1'b0;
      data_reg     <= '0;
      vld_reg      <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      s1_vld_reg <= 1'b0;
      done_reg   <= 1'b0;
      vld_reg    <= s1_vld_reg;
      if (s1_vld_reg) data_reg <= q_data;

      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            num_pass_reg <= (cfg_num_pass == '0) ? PASS_W'(1) : cfg_num_pass;
            num_out_reg  <= cfg_num_out;
            shift_reg    <= cfg_shift;
            bias_reg     <= ACC_W'(cfg_bias);
            pass_cnt_reg <= '0;
            pix_cnt_reg  <= '0;
            // A partial sum arriving with start is dropped and flagged.
            err_reg      <= vld_i;
            if (cfg_num_out == '0) done_reg <= 1'b1;
            else                   state_reg <= ST_RUN;
          end else if (vld_i) begin
            err_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (vld_i) begin
            if (last_pass) begin
              s1_sum_reg   <= pass_sum + bias_reg;
              s1_vld_reg   <= 1'b1;
              pass_cnt_reg <= '0;
              pix_cnt_reg  <= pix_cnt_reg + 1'b1;
              if (last_pix) state_reg <= ST_DRAIN;
            end else begin
              psum_reg     <= pass_sum;
              pass_cnt_reg <= pass_cnt_reg + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          state_reg <= ST_DONE;
          if (vld_i) err_reg <= 1'b1;
        end
        default: begin
          // Leaving DONE lines done_o up with the cycle after the last vld_o.
          state_reg <= ST_IDLE;
          done_reg  <= 1'b1;
          if (vld_i) err_reg <= 1'b1;
        end
      endcase
    end
  end

  assign data_o = data_reg;
  assign vld_o  = vld_reg;
  assign busy_o = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done_o = done_reg;
  assign err_o  = err_reg;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: directed jobs, expected pixels queued with due cycle.
module tb_psum_accumulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_i = 1'b0;
  logic [7:0]         cfg_num_pass = '0;
  logic [15:0]        cfg_num_out = '0;
  logic [4:0]         cfg_shift = '0;
  logic signed [15:0] cfg_bias = '0;
  logic               vld_i = 1'b0;
  logic signed [21:0] acc_i = '0;
  logic signed [7:0]  data_o;
  logic               vld_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_cyc = 0;
  int   s_cyc = 0;

  psum_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .cfg_num_pass (cfg_num_pass),
    .cfg_num_out  (cfg_num_out),
    .cfg_shift    (cfg_shift),
    .cfg_bias     (cfg_bias),
    .vld_i        (vld_i),
    .acc_i        (acc_i),
    .data_o       (data_o),
    .vld_o        (vld_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int np, input int no, input int sh, input int bias,
                           output int s);
    cfg_num_pass = 8'(np);
    cfg_num_out  = 16'(no);
    cfg_shift    = 5'(sh);
    cfg_bias     = 16'(bias);
    start_i      = 1'b1;
    s            = cyc;
    tick();
    start_i      = 1'b0;
  endtask

  task automatic send(input int v, input bit last, input int e);
    exp_t x;
    vld_i = 1'b1;
    acc_i = 22'(v);
    if (last) begin
      x.data = e;
      x.cyc  = cyc + 2;
      sb.push_back(x);
    end
    last_cyc = cyc;
    tick();
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int got;
    got = -1;
    for (int i = 0; i < 20 && got < 0; i++) begin
      @(negedge clk);
      if (done_o) got = cyc;
    end
    check(tag, got, exp_cyc);
    tick();
    check({tag, "_pulse_width"}, int'(done_o), 0);
    check({tag, "_busy_after"}, int'(busy_o), 0);
  endtask

  // Output monitor: one line per produced pixel.
  always @(negedge clk) begin
    if (!rst && vld_o) begin
      if (sb.size() == 0) begin
        check("spurious_vld", int'(vld_o), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("[cyc %0d] pixel data_o=%0d expected=%0d due=%0d", cyc, data_o, e.data, e.cyc);
        check("pixel_data", int'(data_o), e.data);
        check("pixel_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_data", int'(data_o), 0);
    check("rst_vld", int'(vld_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_err", int'(err_o), 0);

    // 1: four passes into one pixel, no bias/shift
    start_job(4, 1, 0, 0, s_cyc);
    check("t1_busy", int'(busy_o), 1);
    send(10, 0, 0);
    send(20, 0, 0);
    send(30, 0, 0);
    send(40, 1, 100);
    vld_i = 1'b0;
    wait_done("t1_done", last_cyc + 3);

    // 2: back-to-back single-pass pixels with bias, shift and saturation
    start_job(1, 3, 2, 2, s_cyc);
    send(5, 1, 2);
    send(-7, 1, -1);
    send(1000, 1, 127);
    vld_i = 1'b0;
    wait_done("t2_done", last_cyc + 3);

    // 3: rounding on both signs
    start_job(1, 2, 1, 0, s_cyc);
    send(3, 1, 2);
    send(-3, 1, -1);
    vld_i = 1'b0;
    wait_done("t3_done", last_cyc + 3);

    // 4: negative values, ReLU-dependent
    start_job(1, 2, 0, 0, s_cyc);
`ifdef PSUM_ACC_RELU_EN
    send(-50, 1, 0);
    send(-1000, 1, 0);
`else
    send(-50, 1, -50);
    send(-1000, 1, -128);
`endif
    vld_i = 1'b0;
    wait_done("t4_done", last_cyc + 3);

    // zero-pixel job finishes on the next cycle
    start_job(1, 0, 0, 0, s_cyc);
    check("t0_busy", int'(busy_o), 0);
    wait_done("t0_done", s_cyc + 1);

    // 5: error and ignore cases
    vld_i = 1'b1;
    acc_i = 22'(5);
    tick();
    vld_i = 1'b0;
    check("t5_err_idle", int'(err_o), 1);
    repeat (3) tick();
    start_job(2, 1, 0, 0, s_cyc);
    check("t5_err_cleared", int'(err_o), 0);
    send(7, 0, 0);
    vld_i = 1'b0;
    tick();
    start_job(1, 4, 3, 9, s_cyc);
    send(8, 1, 15);
    vld_i = 1'b0;
    check("t5_err_run", int'(err_o), 0);
    wait_done("t5_done", last_cyc + 3);

    vld_i = 1'b1;
    acc_i = 22'(99);
    start_job(1, 1, 0, 0, s_cyc);
    vld_i = 1'b0;
    check("t5_err_start_vld", int'(err_o), 1);
    send(5, 1, 5);
    vld_i = 1'b0;
    wait_done("t5b_done", last_cyc + 3);

    // 6: reset in the middle of a pixel, then a clean job
    start_job(4, 1, 0, 0, s_cyc);
    send(1, 0, 0);
    send(1, 0, 0);
    vld_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", int'(busy_o), 0);
    check("t6_err", int'(err_o), 0);
    repeat (4) tick();
    start_job(4, 1, 0, 0, s_cyc);
    for (int i = 0; i < 3; i++) send(1, 0, 0);
    send(1, 1, 4);
    vld_i = 1'b0;
    wait_done("t6_done", last_cyc + 3);

    repeat (4) tick();
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
